// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and its peripherals (slave).
// Slave k returns read data on PRDATA[32k+31:32k] and ready on PREADY[k].
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  logic [31:0]              PADDR;
  logic                     PWRITE;
  logic [31:0]              PWDATA;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic                     PENABLE;
  logic [32*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;

  modport master (
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master bridge.
// Takes a CPU-side request, decodes the slave window from addr[15:12], runs
// the SETUP/ACCESS phases and returns a one-cycle done pulse, with err set on
// decode failure or when the selected slave never raises PREADY.
module apb_master_bridge #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_HI    = 16'h1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                req,
  input  logic                write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                done,
  output logic                err,
  output logic                busy,
  apb_master_bridge_if.master apb
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [4:0]     NS       = 5'(NUM_SLAVES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [NUM_SLAVES-1:0] PSEL_NONE = {NUM_SLAVES{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [CW-1:0]         cnt_r, cnt_next_s;
  logic                  ready_sel_s;
  logic [31:0]           rdata_sel_s;
  logic [31:0]           paddr_next_s, pwdata_next_s, rdata_next_s;
  logic                  pwrite_next_s, penable_next_s;
  logic                  done_next_s, err_next_s, busy_next_s;
  logic [NUM_SLAVES-1:0] psel_next_s;

  // Address is valid only inside the bridge window and on an existing slave.
  // The value decoded here is exactly what gets captured into PADDR.
  function automatic logic addr_valid(input logic [31:0] a);
    return (a[31:16] == BASE_HI) && ({1'b0, a[15:12]} < NS);
  endfunction

  // One-hot PSEL pattern for a slave index.
  function automatic logic [NUM_SLAVES-1:0] sel_onehot(input logic [3:0] sel);
    logic [NUM_SLAVES-1:0] oh;
    oh = PSEL_NONE;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      oh[k] = (sel == 4'(k));
    end
    return oh;
  endfunction

  // Return path mux: PSEL is one-hot, so masking with it selects the slave
  // and drops PREADY/PRDATA from every unselected slave.
  always_comb begin
    ready_sel_s = |(apb.PREADY & apb.PSEL);
    rdata_sel_s = 32'd0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      rdata_sel_s = rdata_sel_s | (apb.PRDATA[32*k +: 32] & {32{apb.PSEL[k]}});
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    paddr_next_s   = apb.PADDR;
    pwrite_next_s  = apb.PWRITE;
    pwdata_next_s  = apb.PWDATA;
    psel_next_s    = apb.PSEL;
    penable_next_s = apb.PENABLE;
    rdata_next_s   = rdata;
    done_next_s    = 1'b0;
    err_next_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        psel_next_s    = PSEL_NONE;
        penable_next_s = 1'b0;
        if (req) begin
          paddr_next_s  = addr;
          pwrite_next_s = write;
          pwdata_next_s = wdata;
          if (addr_valid(addr)) begin
            state_next_s = ST_SETUP;
            psel_next_s  = sel_onehot(addr[15:12]);
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s   = ST_ACCESS;
        penable_next_s = 1'b1;
      end
      ST_ACCESS: begin
        if (ready_sel_s) begin
          state_next_s   = ST_IDLE;
          done_next_s    = 1'b1;
          psel_next_s    = PSEL_NONE;
          penable_next_s = 1'b0;
          cnt_next_s     = CNT_ZERO;
          if (!apb.PWRITE) begin
            rdata_next_s = rdata_sel_s;
          end else begin
            rdata_next_s = rdata;
          end
        end else if (cnt_r == CNT_LAST) begin
          // Last allowed ACCESS cycle passed without PREADY: abort.
          state_next_s   = ST_IDLE;
          done_next_s    = 1'b1;
          err_next_s     = 1'b1;
          rdata_next_s   = 32'd0;
          psel_next_s    = PSEL_NONE;
          penable_next_s = 1'b0;
          cnt_next_s     = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_ERR: begin
        state_next_s = ST_IDLE;
        done_next_s  = 1'b1;
        err_next_s   = 1'b1;
        rdata_next_s = 32'd0;
      end
      default: begin
        state_next_s   = ST_IDLE;
        psel_next_s    = PSEL_NONE;
        penable_next_s = 1'b0;
        cnt_next_s     = CNT_ZERO;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, timeout counter and all outputs registered; reset abandons any transfer.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      rdata       <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      apb.PADDR   <= 32'd0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= 32'd0;
      apb.PSEL    <= PSEL_NONE;
      apb.PENABLE <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      rdata       <= rdata_next_s;
      done        <= done_next_s;
      err         <= err_next_s;
      busy        <= busy_next_s;
      apb.PADDR   <= paddr_next_s;
      apb.PWRITE  <= pwrite_next_s;
      apb.PWDATA  <= pwdata_next_s;
      apb.PSEL    <= psel_next_s;
      apb.PENABLE <= penable_next_s;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers,
// checked against a transaction-level model of slave contents and latencies.
module tb_apb_master_bridge;
  localparam int NS = 4;
  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req, write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        done, err, busy;

  apb_master_bridge_if #(.NUM_SLAVES(NS)) apb ();

  apb_master_bridge #(.NUM_SLAVES(NS), .BASE_HI(16'h1000), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy), .apb(apb)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave models: slave 0 is a GPIO-style block with a registered PREADY and
  // one control register; slaves 1..3 answer after lat[k] ACCESS cycles, or
  // never when hang[k] is set. Unselected slaves drive random noise.
  logic [31:0]   sreg [NS];
  logic [3:0]    wcnt [NS];
  logic [3:0]    lat  [NS];
  logic [NS-1:0] hang;
  logic          gpio_rdy;
  logic [NS-1:0] slave_rdy;
  logic [NS-1:0] junk_rdy;
  logic [31:0]   junk_data [NS];

  // Model of what the slaves should hold, and of the bridge's rdata.
  logic [31:0] exp_mem [NS];
  logic [31:0] exp_rdata;
  logic [31:0] ra, rd;
  int          r;

  function automatic logic [31:0] sreg_reset(input int k);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_00A5;
      2:       return 32'h2222_C0DE;
      default: return 32'h3333_BEEF;
    endcase
  endfunction

  // Slave register state and wait counters.
  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      gpio_rdy <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        sreg[k] <= sreg_reset(k);
        wcnt[k] <= 4'd0;
      end
    end else begin
      gpio_rdy <= apb.PSEL[0] & apb.PENABLE & ~gpio_rdy;
      if (apb.PSEL[0] && apb.PENABLE && slave_rdy[0] && apb.PWRITE) sreg[0] <= apb.PWDATA;
      for (int k = 1; k < NS; k++) begin
        if (apb.PSEL[k] && apb.PENABLE) begin
          if (slave_rdy[k] && apb.PWRITE) sreg[k] <= apb.PWDATA;
          wcnt[k] <= wcnt[k] + 4'd1;
        end else begin
          wcnt[k] <= 4'd0;
        end
      end
    end
  end

  // Per-slave ready condition while addressed.
  always_comb begin
    slave_rdy    = '0;
    slave_rdy[0] = gpio_rdy & ~hang[0];
    for (int k = 1; k < NS; k++) slave_rdy[k] = (wcnt[k] == lat[k]) & ~hang[k];
  end

  // Noise generator for unselected slaves.
  always @(negedge PCLK) begin
    junk_rdy <= NS'($urandom);
    for (int k = 0; k < NS; k++) junk_data[k] <= $urandom;
  end

  // Slave return buses.
  always_comb begin
    apb.PREADY = '0;
    apb.PRDATA = '0;
    for (int k = 0; k < NS; k++) begin
      if (apb.PSEL[k] && apb.PENABLE) begin
        apb.PREADY[k]          = slave_rdy[k];
        apb.PRDATA[32*k +: 32] = sreg[k];
      end else begin
        apb.PREADY[k]          = junk_rdy[k];
        apb.PRDATA[32*k +: 32] = junk_data[k];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) exp_mem[k] = sreg_reset(k);
    exp_rdata = 32'd0;
  endtask

  // Issue one request in the current cycle and follow it to its done pulse.
  // With keep set, req stays high and the other inputs churn while busy.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic keep);
    logic [3:0]    sel;
    logic [1:0]    s2;
    logic          valid, exp_err, seen;
    logic [NS-1:0] oh;
    int            exp_k, k;
    sel   = a[15:12];
    s2    = sel[1:0];
    valid = (a[31:16] == 16'h1000) && (sel < 4'd4);
    oh    = valid ? (NS'(1) << sel) : NS'(0);
    if (!valid) begin
      exp_k = 2; exp_err = 1'b1;
    end else if (hang[s2]) begin
      exp_k = 2 + TO; exp_err = 1'b1;
    end else if (s2 == 2'd0) begin
      exp_k = 4; exp_err = 1'b0;
    end else begin
      exp_k = 3 + int'(lat[s2]); exp_err = 1'b0;
    end
    req = 1'b1; write = w; addr = a; wdata = d;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge PCLK);
      k++;
      if (!keep) req = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        check_eq("bus", 64'({apb.PSEL, apb.PENABLE, busy, err}),
                 64'({oh, (valid && k >= 2), 1'b1, 1'b0}));
        check_eq("captured", 64'({apb.PWRITE, apb.PADDR}), 64'({w, a}));
        check_eq("pwdata", 64'(apb.PWDATA), 64'(d));
        if (keep) begin
          addr = $urandom; wdata = $urandom; write = ~write;
        end
      end
    end
    check_eq("done_seen", 64'(seen), 64'(1));
    check_eq("latency", 64'(k), 64'(exp_k));
    if (valid && !exp_err) begin
      if (w) exp_mem[s2] = d;
      else   exp_rdata = exp_mem[s2];
    end else begin
      exp_rdata = 32'd0;
    end
    check_eq("done_cycle", 64'({apb.PSEL, apb.PENABLE, busy, err}), 64'({NS'(0), 1'b0, 1'b0, exp_err}));
    check_eq("rdata", 64'(rdata), 64'(exp_rdata));
    if (valid && w && !exp_err) check_eq("slave_wr", 64'(sreg[s2]), 64'(d));
  endtask

  initial begin
    PRESET = 1'b0; req = 1'b0; write = 1'b0; addr = 32'd0; wdata = 32'd0;
    hang = '0;
    for (int k = 0; k < NS; k++) lat[k] = 4'd0;
    model_reset();

    // Reset and idle state
    repeat (3) @(negedge PCLK);
    check_eq("rst_ctl", 64'({done, err, busy, apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'd0);
    check_eq("rst_data", 64'({rdata, apb.PADDR}), 64'd0);
    PRESET = 1'b1;
    repeat (5) @(negedge PCLK);
    check_eq("idle_ctl", 64'({done, err, busy, apb.PSEL, apb.PENABLE, apb.PWRITE}), 64'd0);
    check_eq("idle_data", 64'({rdata, apb.PWDATA}), 64'd0);

    // GPIO write then read-back of its control register
    run_txn(1'b1, 32'h1000_0000, 32'h0000_00FF, 1'b0);
    run_txn(1'b0, 32'h1000_0000, 32'h0000_0000, 1'b0);

    // Slave 1 read, then a write that must leave rdata alone
    lat[1] = 4'd0;
    run_txn(1'b0, 32'h1000_1004, 32'h0000_0000, 1'b0);
    check_eq("rdata_a5", 64'(rdata), 64'h0000_00A5);
    lat[1] = 4'd2;
    run_txn(1'b1, 32'h1000_1000, 32'h1234_5678, 1'b0);
    check_eq("rdata_kept", 64'(rdata), 64'h0000_00A5);

    // PREADY never comes: timeout abort clears rdata
    hang[2] = 1'b1;
    run_txn(1'b0, 32'h1000_2000, 32'h0000_0000, 1'b0);
    hang[2] = 1'b0;

    // Decode errors: wrong upper half, slave index beyond range
    run_txn(1'b0, 32'h2000_0000, 32'h0000_0000, 1'b0);
    run_txn(1'b1, 32'h1000_7000, 32'hDEAD_BEEF, 1'b0);

    // Reset in the middle of an ACCESS phase
    hang[3] = 1'b1;
    req = 1'b1; write = 1'b0; addr = 32'h1000_3000; wdata = 32'd0;
    @(negedge PCLK); req = 1'b0;
    @(negedge PCLK);
    check_eq("pre_reset", 64'({apb.PSEL, apb.PENABLE, busy}), 64'({4'b1000, 1'b1, 1'b1}));
    #2 PRESET = 1'b0;
    #1 check_eq("async_reset", 64'({apb.PSEL, apb.PENABLE, busy, done, err}), 64'd0);
    model_reset();
    @(negedge PCLK);
    check_eq("no_done_rst", 64'({done, err, rdata}), 64'd0);
    PRESET = 1'b1;
    hang[3] = 1'b0;
    lat[3] = 4'd1;
    run_txn(1'b0, 32'h1000_3008, 32'h0000_0000, 1'b0);

    // Back-to-back GPIO writes with req held high
    run_txn(1'b1, 32'h1000_0000, 32'hAAAA_0001, 1'b1);
    run_txn(1'b1, 32'h1000_0004, 32'hBBBB_0002, 1'b1);
    req = 1'b0;
    @(negedge PCLK);
    check_eq("pulse_end", 64'({done, err, busy}), 64'd0);
    check_eq("rdata_hold", 64'(rdata), 64'(exp_rdata));

    // Randomized transfers
    for (int t = 0; t < 60; t++) begin
      for (int k = 1; k < NS; k++) begin
        lat[k]  = 4'($urandom_range(0, 3));
        hang[k] = ($urandom_range(0, 19) == 0);
      end
      r  = $urandom_range(0, 9);
      rd = $urandom;
      if (r < 7)      ra = {16'h1000, 4'($urandom_range(0, 3)), 10'($urandom), 2'b00};
      else if (r < 9) ra = {16'h1000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
      else            ra = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
      run_txn(1'($urandom), ra, rd, 1'($urandom));
    end
    req = 1'b0;
    @(negedge PCLK);
    check_eq("final_idle", 64'({done, err, busy, apb.PSEL, apb.PENABLE}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
